// File: rtl/rv_mem_arb_if.sv
// rv_mem_arb_if
// Bundles every bus signal of the rv_mem_arb memory arbiter into one
// interface. Its three channels are:
//   m0_*  : instruction-fetch master  (req/addr/we/wdata in, gnt/rsp/rdata/err out)
//   m1_*  : load/store master         (same shape as m0_*)
//   s_*   : shared memory slave       (req/addr/we/wdata out, ready/rsp/rdata in)
// Modports:
//   master : the arbiter's view. It arbitrates the two masters and masters
//            the single memory port.
//   slave  : the environment's view. This is the requesting masters plus the
//            memory slave, as used by a bench or by the surrounding SoC glue.
// Parameters:
//   AW : address width
//   DW : data width
interface rv_mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  // Master 0 (instruction fetch)
  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic          m0_we;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rsp;
  logic [DW-1:0] m0_rdata;
  logic          m0_err;

  // Master 1 (load/store)
  logic          m1_req;
  logic [AW-1:0] m1_addr;
  logic          m1_we;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rsp;
  logic [DW-1:0] m1_rdata;
  logic          m1_err;

  // Shared slave port
  logic          s_req;
  logic [AW-1:0] s_addr;
  logic          s_we;
  logic [DW-1:0] s_wdata;
  logic          s_ready;
  logic          s_rsp;
  logic [DW-1:0] s_rdata;

  modport master (
    input  m0_req, m0_addr, m0_we, m0_wdata,
    output m0_gnt, m0_rsp, m0_rdata, m0_err,
    input  m1_req, m1_addr, m1_we, m1_wdata,
    output m1_gnt, m1_rsp, m1_rdata, m1_err,
    output s_req, s_addr, s_we, s_wdata,
    input  s_ready, s_rsp, s_rdata
  );

  modport slave (
    output m0_req, m0_addr, m0_we, m0_wdata,
    input  m0_gnt, m0_rsp, m0_rdata, m0_err,
    output m1_req, m1_addr, m1_we, m1_wdata,
    input  m1_gnt, m1_rsp, m1_rdata, m1_err,
    input  s_req, s_addr, s_we, s_wdata,
    output s_ready, s_rsp, s_rdata
  );

endinterface

// File: rtl/rv_mem_arb.sv
// rv_mem_arb
// Two-master, single-slave memory arbiter. The instruction-fetch master (m0)
// and the load/store master (m1) share one memory port. Exactly one
// transaction is in flight at a time. The arbiter forwards it to the slave,
// routes the response back to the master that issued it, and answers with an
// error response if the slave stays silent for TMO_CYC cycles.
//
// Ports:
//   clk : system clock
//   rst : asynchronous, active-low reset
//   bus : rv_mem_arb_if.master
//         m0_*/m1_* : request side. gnt is combinational and only asserted
//                     in IDLE. rsp is a one-cycle pulse, with rdata/err valid
//                     in that same cycle.
//         s_*       : slave side. s_req is held with stable fields until
//                     s_ready. s_rsp completes both reads and writes.
//
// Parameters:
//   AW      : address width (must match the interface)
//   DW      : data width (must match the interface)
//   TMO_CYC : number of WAIT cycles before an error response; 0 disables it
//
// Configuration macro:
//   RV_ARB_RR_EN : when defined, simultaneous requests are arbitrated
//                  round-robin: the master that was not served last wins.
//                  When undefined, fixed priority applies (m1 over m0) and
//                  no pointer state is kept.
module rv_mem_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TMO_CYC = 255
) (
  input  logic         clk,
  input  logic         rst,
  rv_mem_arb_if.master bus
);

  // Counter width. It is still one bit when the timeout is disabled, so that
  // the register stays legal.
  localparam int CW = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = (TMO_CYC > 0) ? CW'(TMO_CYC - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // The captured transaction. owner is 0 for m0 and 1 for m1.
  logic          owner;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;

  logic [CW-1:0] cnt;
  logic          err_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  logic          pick_m1;
  logic          gnt0;
  logic          gnt1;
  logic          s_req_c;
  logic          tmo_fire;
  logic          rsp_capture;
  logic [DW-1:0] rsp_data;
  logic          rsp0;
  logic          rsp1;

`ifdef RV_ARB_RR_EN
  // Remembers who was served last. The reset value (0) means m0, so m1 wins
  // the first tie after reset.
  logic          last_m1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_m1 <= 1'b0;
    end else if (gnt0 || gnt1) begin
      last_m1 <= gnt1;
    end
  end

  // A lone requester always wins. On a tie, the master not served last wins.
  always_comb begin
    pick_m1 = bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      pick_m1 = !last_m1;
    end
  end
`else
  // Fixed priority: m1 wins whenever it requests.
  always_comb begin
    pick_m1 = bus.m1_req;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, grant and slave request.
  // The timeout only fires while no s_rsp is present, so a real response
  // arriving in the last WAIT cycle still wins.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    s_req_c   = 1'b0;
    tmo_fire  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          gnt1      = pick_m1;
          gnt0      = !pick_m1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        s_req_c = 1'b1;
        if (bus.s_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.s_rsp) begin
          state_nxt = S_RESP;
        end else if ((TMO_CYC != 0) && (cnt == TMO_LAST)) begin
          tmo_fire  = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign rsp_capture = (state == S_WAIT) && (bus.s_rsp || tmo_fire);
  assign rsp_data    = bus.s_rsp ? bus.s_rdata : '0;

  // Datapath registers.
  // Request fields are captured on the grant edge, so a master may change
  // them right after its grant. The counter is cleared throughout ISSUE,
  // which means WAIT always starts counting from zero. The counter saturates
  // instead of wrapping. Read data is kept per master, so the master that
  // does not own the response keeps its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner    <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (gnt0 || gnt1) begin
        owner   <= gnt1;
        addr_q  <= gnt1 ? bus.m1_addr  : bus.m0_addr;
        we_q    <= gnt1 ? bus.m1_we    : bus.m0_we;
        wdata_q <= gnt1 ? bus.m1_wdata : bus.m0_wdata;
      end
      if (state == S_ISSUE) begin
        cnt <= '0;
      end else if ((state == S_WAIT) && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
      if (rsp_capture) begin
        err_q <= tmo_fire;
        if (owner) begin
          rdata1_q <= rsp_data;
        end else begin
          rdata0_q <= rsp_data;
        end
      end
    end
  end

  assign rsp0 = (state == S_RESP) && !owner;
  assign rsp1 = (state == S_RESP) && owner;

  assign bus.m0_gnt   = gnt0;
  assign bus.m1_gnt   = gnt1;
  assign bus.m0_rsp   = rsp0;
  assign bus.m1_rsp   = rsp1;
  assign bus.m0_err   = rsp0 && err_q;
  assign bus.m1_err   = rsp1 && err_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;

  assign bus.s_req   = s_req_c;
  assign bus.s_addr  = addr_q;
  assign bus.s_we    = we_q;
  assign bus.s_wdata = wdata_q;

endmodule
